// File: rtl/reg4_pkg.sv
// rtl/reg4_pkg.sv - shared constants and word type for the reg4 data register
package reg4_pkg;

    localparam int REG4_DEFAULT_WIDTH = 4;

    typedef logic [REG4_DEFAULT_WIDTH-1:0] reg4_word_t;

    localparam reg4_word_t REG4_DEFAULT_RESET = '0;

endpackage

// File: rtl/reg4_bit.sv
// rtl/reg4_bit.sv - single-bit async-reset D flop with capture enable
module reg4_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = en_i ? d_i : q_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg4.sv
// rtl/reg4.sv - parallel-load data register; REG4_LOAD_EN adds a load enable port
module reg4
    import reg4_pkg::*;
#(
    parameter int               WIDTH       = REG4_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG4_DEFAULT_RESET)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
`ifdef REG4_LOAD_EN
    input  logic             load,
`endif
    output logic [WIDTH-1:0] d_out
);

    logic capture_en;

`ifdef REG4_LOAD_EN
    assign capture_en = load;
`else
    assign capture_en = 1'b1;
`endif

    // Each bit carries its own reset value so RESET_VALUE can be any pattern.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        reg4_bit #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .en_i(capture_en),
            .d_i (data[i]),
            .q_o (d_out[i])
        );
    end

`ifndef SYNTHESIS
    a_reset_value: assert property (@(posedge clk) rst |-> (d_out == RESET_VALUE));

`ifdef REG4_LOAD_EN
    a_capture: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> (d_out == ($past(load) ? $past(data) : $past(d_out))));
`else
    a_capture: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> (d_out == $past(data)));
`endif
`endif

endmodule

// File: tb/tb_reg4.sv
// tb/tb_reg4.sv - directed self-checking bench for reg4 (REG4_LOAD_EN steps included when defined)
module tb_reg4;

    logic       clk;
    logic       rst;
    logic [3:0] data;
`ifdef REG4_LOAD_EN
    logic       load;
`endif
    logic [3:0] d_out;

    int vectors;
    int miscompares;

    reg4 #(
        .WIDTH      (4),
        .RESET_VALUE(4'b0000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
`ifdef REG4_LOAD_EN
        .load (load),
`endif
        .d_out(d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic at(input longint t);
        #(t - longint'($time));
    endtask

    task automatic check(input string tag, input logic [3:0] expected);
        vectors++;
        assert (d_out === expected) else begin
            miscompares++;
            $error("FAIL %s: d_out=%b expected=%b at t=%0t", tag, d_out, expected, $time);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        data = 4'b0000;
`ifdef REG4_LOAD_EN
        load = 1'b1;
`endif

        at(1);   check("reset_t1", 4'b0000);
        at(7);   check("reset_across_edge", 4'b0000);
        at(10);  rst = 1'b0;
        at(12);  check("release_no_edge", 4'b0000);
        at(20);  data = 4'b1010;
        at(22);  check("before_capture_1010", 4'b0000);
        at(27);  check("capture_1010", 4'b1010);
        at(30);  data = 4'b1100;
        at(37);  check("capture_1100", 4'b1100);
        at(40);  data = 4'b0011;
        at(47);  check("capture_0011", 4'b0011);

        at(50);  rst = 1'b1;
        at(51);  check("async_reset", 4'b0000);
        at(57);  check("reset_dominates_edge", 4'b0000);
        at(60);  rst = 1'b0;
        at(62);  check("release_before_edge", 4'b0000);
        at(67);  check("first_capture_after_release", 4'b0011);
        at(70);  check("hold_t70", 4'b0011);
        at(80);  check("hold_t80", 4'b0011);

        data = 4'b0101;
        at(82);  check("midcycle_0101_no_effect", 4'b0011);
        at(83);  data = 4'b1001;
        at(84);  check("midcycle_1001_no_effect", 4'b0011);
        at(87);  check("capture_last_before_edge", 4'b1001);
        at(90);  data = 4'b0110;
        at(92);  check("midcycle_0110_no_effect", 4'b1001);
        at(97);  check("capture_0110", 4'b0110);

`ifdef REG4_LOAD_EN
        at(100); load = 1'b0; data = 4'b1111;
        at(107); check("load0_hold_a", 4'b0110);
        at(117); check("load0_hold_b", 4'b0110);
        at(120); load = 1'b1;
        at(127); check("load_pulse_capture", 4'b1111);
        at(130); load = 1'b0; data = 4'b0000;
        at(137); check("load0_hold_after_pulse", 4'b1111);
        at(140); rst = 1'b1;
        at(142); check("reset_with_load0", 4'b0000);
`else
        at(100); data = 4'b1111;
        at(107); check("capture_1111", 4'b1111);
        at(110); rst = 1'b1;
        at(112); check("async_reset_from_1111", 4'b0000);
        at(117); check("reset_held_edge", 4'b0000);
        at(120); rst = 1'b0; data = 4'b0001;
        at(127); check("capture_0001", 4'b0001);
`endif

        at(150);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
